// File: rtl/spi_slave_rx.sv
// SPI target receiver: oversampled, synchronised SPI inputs are deserialised MSB-first
// into D/C-tagged bytes and queued in a show-ahead FIFO with a valid/ready read port.
module spi_slave_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       spi_dc,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overflow
);

  // state     | meaning
  // WAIT_IDLE | after reset, wait for cs_n high so a frame in flight is ignored
  // IDLE      | cs_n high, waiting for cs_n fall
  // SHIFT     | cs_n low, shifting bits on sck rising edges
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Vector bit order: 3 sck, 2 mosi, 1 cs_n, 0 dc
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0] sync_s;
  logic [3:0] prev_q, prev_d;
  logic       sck_rise_q, sck_rise_d;
  logic       cs_fall_q, cs_fall_d;
  logic       cs_rise_q, cs_rise_d;
  logic       mosi_q, mosi_d;
  logic       dc_q, dc_d;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       push;
  logic [8:0] push_word;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [8:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          overflow_q, overflow_d;
  logic          full, do_pop, do_push;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], spi_sck, spi_mosi, spi_cs_n, spi_dc};
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  // Edge strobes are registered, with mosi/dc delayed alongside to stay aligned
  always_comb begin
    prev_d     = sync_s;
    sck_rise_d = sync_s[3] & ~prev_q[3];
    cs_fall_d  = ~sync_s[1] & prev_q[1];
    cs_rise_d  = sync_s[1] & ~prev_q[1];
    mosi_d     = sync_s[2];
    dc_d       = sync_s[0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    push_word = '0;
    frame_err = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (sync_s[1]) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = 3'd0;
        if (cs_fall_q) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_rise_q) begin
          state_d   = IDLE;
          cnt_d     = 3'd0;
          frame_err = (cnt_q != 3'd0);
        end else if (sck_rise_q) begin
          shift_d = {shift_q[5:0], mosi_q};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            push      = 1'b1;
            push_word = {dc_q, shift_q, mosi_q};
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign full     = (fcnt_q == CW'(FIFO_DEPTH));
  assign rx_valid = (fcnt_q != '0);
  assign do_pop   = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot the push lands in
  assign do_push  = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_word;
    wr_ptr_d   = wr_ptr_q + AW'(do_push);
    rd_ptr_d   = rd_ptr_q + AW'(do_pop);
    fcnt_d     = fcnt_q + CW'(do_push) - CW'(do_pop);
    overflow_d = overflow_q | (push & full & ~do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q     <= 4'b1010;
      sck_rise_q <= 1'b0;
      cs_fall_q  <= 1'b0;
      cs_rise_q  <= 1'b0;
      mosi_q     <= 1'b0;
      dc_q       <= 1'b0;
      state_q    <= WAIT_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      sck_rise_q <= sck_rise_d;
      cs_fall_q  <= cs_fall_d;
      cs_rise_q  <= cs_rise_d;
      mosi_q     <= mosi_d;
      dc_q       <= dc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign {rx_dc, rx_data} = mem_q[rd_ptr_q];
  assign busy             = (state_q == SHIFT) && (cnt_q != 3'd0);
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI frames at the pins and checks
// latency, FIFO ordering, overflow, framing errors and reset behaviour.
module tb_spi_slave_rx;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_sck, spi_mosi, spi_cs_n, spi_dc;
  logic [7:0] rx_data;
  logic       rx_dc, rx_valid, rx_ready;
  logic       busy, frame_err, overflow;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;
  int fe0;
  logic [8:0] popq[$];

  spi_slave_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_dc(spi_dc),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    #1;
    if (rx_valid && rx_ready) popq.push_back({rx_dc, rx_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic d);
    @(negedge clk);
    spi_sck  = 1'b0;
    spi_mosi = b;
    spi_dc   = d;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    for (int i = 7; i >= 0; i--) send_bit(b[i], d);
  endtask

  // Last bit drives only up to the sck rise, leaving the caller to time the edges after it
  task automatic last_bit_rise(input logic b, input logic d);
    @(negedge clk);
    spi_sck  = 1'b0;
    spi_mosi = b;
    spi_dc   = d;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b1;
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_dc   = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (8) @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    logic [8:0] exp3 [3];
    logic [8:0] exp5 [5];

    reset_n  = 1'b0;
    spi_sck  = 1'b1;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b0;
    spi_dc   = 1'b0;
    rx_ready = 1'b0;

    // Reset with a frame already in flight
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_dc", rx_dc, 1'b0);
    b = 8'hFF;
    send_byte(b, 1'b1);
    repeat (6) @(negedge clk);
    check("inflight_valid", rx_valid, 1'b0);
    check("inflight_busy", busy, 1'b0);
    check("inflight_data", rx_data, 8'h00);
    cs_high();
    check("inflight_ferr_cnt", fe_cnt, 0);

    // Single byte A5, dc=1: latency and busy
    cs_low();
    check("a5_busy_pre", busy, 1'b0);
    b = 8'hA5;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i], 1'b1);
      check("a5_busy_bit", busy, 1'b1);
    end
    last_bit_rise(b[0], 1'b1);
    repeat (3) @(posedge clk);
    #1 check("a5_valid_edge3", rx_valid, 1'b0);
    @(posedge clk);
    #1 check("a5_valid_edge4", rx_valid, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_dc", rx_dc, 1'b1);
    check("a5_busy_post", busy, 1'b0);
    cs_high();
    check("a5_ferr_cnt", fe_cnt, 0);
    popq.delete();
    drain();
    check("a5_pop_n", popq.size(), 1);
    if (popq.size() >= 1) check("a5_pop0", popq[0], 9'h1A5);
    check("a5_empty", rx_valid, 1'b0);

    // Three bytes in one window, consumer always ready
    popq.delete();
    fe0 = fe_cnt;
    rx_ready = 1'b1;
    cs_low();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b0);
    cs_high();
    rx_ready = 1'b0;
    exp3[0] = 9'h000; exp3[1] = 9'h1FF; exp3[2] = 9'h03C;
    check("multi_n", popq.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < popq.size()) check("multi_pop", popq[i], exp3[i]);
    check("multi_ferr", fe_cnt - fe0, 0);
    check("multi_empty", rx_valid, 1'b0);

    // Overflow: 5 bytes into a 4-deep FIFO
    popq.delete();
    cs_low();
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0);
    cs_high();
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", rx_data, 8'h01);
    drain();
    check("ovf_pop_n", popq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < popq.size()) check("ovf_pop", popq[i], 9'(i + 1));
    check("ovf_sticky", overflow, 1'b1);
    pulse_reset();
    check("ovf_cleared", overflow, 1'b0);

    // Pop coinciding with the 5th push
    popq.delete();
    cs_low();
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
    b = 8'h05;
    for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b0);
    last_bit_rise(b[0], 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    check("pp_ovf", overflow, 1'b0);
    check("pp_valid", rx_valid, 1'b1);
    check("pp_head", rx_data, 8'h02);
    cs_high();
    drain();
    check("pp_pop_n", popq.size(), 5);
    for (int i = 0; i < 5; i++) exp5[i] = 9'(i + 1);
    for (int i = 0; i < 5; i++)
      if (i < popq.size()) check("pp_pop", popq[i], exp5[i]);

    // Partial byte then 81
    popq.delete();
    fe0 = fe_cnt;
    cs_low();
    b = 8'hC6;
    for (int i = 7; i >= 3; i--) send_bit(b[i], 1'b0);
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_dc   = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("fe_edge2", frame_err, 1'b0);
    @(posedge clk);
    #1 check("fe_edge3", frame_err, 1'b1);
    @(posedge clk);
    #1 check("fe_edge4", frame_err, 1'b0);
    repeat (6) @(negedge clk);
    cs_low();
    send_byte(8'h81, 1'b0);
    cs_high();
    check("fe_cnt", fe_cnt - fe0, 1);
    drain();
    check("fe_pop_n", popq.size(), 1);
    if (popq.size() >= 1) check("fe_pop0", popq[0], 9'h081);

    // Reset during bit 4 with two bytes queued
    popq.delete();
    fe0 = fe_cnt;
    cs_low();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("mr_two_queued", rx_valid, 1'b1);
    b = 8'h33;
    for (int i = 7; i >= 5; i--) send_bit(b[i], 1'b0);
    @(negedge clk);
    spi_sck  = 1'b0;
    spi_mosi = b[4];
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    check("mr_valid", rx_valid, 1'b0);
    check("mr_ovf", overflow, 1'b0);
    check("mr_data", rx_data, 8'h00);
    check("mr_busy", busy, 1'b0);
    for (int i = 3; i >= 0; i--) send_bit(b[i], 1'b0);
    cs_high();
    check("mr_ferr", fe_cnt - fe0, 0);
    check("mr_no_push", rx_valid, 1'b0);
    cs_low();
    send_byte(8'h5A, 1'b1);
    cs_high();
    drain();
    check("mr_pop_n", popq.size(), 1);
    if (popq.size() >= 1) check("mr_pop0", popq[0], 9'h15A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
